// File: rtl/spi_lcd_target.sv
// Panel-side receiver for a 4-wire SPI LCD link: oversampled SPI, ST7789-style command subset, RGB565 pixel writes.
// Optional RDDID readback on LCD_miso when SPI_LCD_TARGET_READ_EN is defined; otherwise LCD_miso is tied low.
module spi_lcd_target #(
   parameter int W     = 240,
   parameter int H     = 240,
   parameter int FREQ  = 25_000_000,
   parameter int DELAY = 120,
   localparam int XW   = $clog2(W),
   localparam int YW   = $clog2(H)
) (
   input  logic          reset,
   input  logic          clock,
   input  logic          LCD_reset_n,
   input  logic          LCD_clock,
   input  logic          LCD_cs_n,
   input  logic          LCD_dc,
   input  logic          LCD_mosi,
   output logic          LCD_miso,
   output logic [XW-1:0] px_x,
   output logic [YW-1:0] px_y,
   output logic [15:0]   px_data,
   output logic          px_put,
   input  logic          px_full,
   output logic          sleep,
   output logic          disp_on,
   output logic          busy,
   output logic          error,
   output logic          overrun
);
   localparam int TIMEOUT = DELAY * (FREQ / 1000);
   localparam int TW      = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, CASET, RASET, RAMWR} state_t;

   typedef struct packed {
      logic [15:0] xs, xe, ys, ye, x, y;
      state_t      state;
      logic [2:0]  pidx;
      logic        hi_valid;
      logic [7:0]  hi;
      logic        sleep;
      logic        disp_on;
   } regs_t;

   localparam regs_t REGS_RST = '{xs: 16'd0, xe: 16'(W - 1), ys: 16'd0, ye: 16'(H - 1),
                                  x: 16'd0, y: 16'd0, state: IDLE, pidx: 3'd0,
                                  hi_valid: 1'b0, hi: 8'd0, sleep: 1'b1, disp_on: 1'b0};
   // Synchronizer bit order: {reset_n, sck, cs_n, dc, mosi}
   localparam logic [4:0] SYNC_IDLE = 5'b10100;

   logic [4:0]    r_sync1, r_sync2;
   logic          r_sck_d;
   logic [6:0]    r_shift;
   logic [2:0]    r_bitcnt;
   logic          r_byte_valid, r_byte_dc;
   logic [7:0]    r_byte;
   regs_t         r_st;
   logic [TW-1:0] r_timer;
   logic          r_px_put, r_error, r_overrun;
   logic [XW-1:0] r_px_x;
   logic [YW-1:0] r_px_y;
   logic [15:0]   r_px_data;

   logic       w_lrst, w_sck, w_cs_n, w_dc, w_mosi, w_rise;
   logic [7:0] w_byte_full;

   assign w_lrst      = ~r_sync2[4];
   assign w_sck       = r_sync2[3];
   assign w_cs_n      = r_sync2[2];
   assign w_dc        = r_sync2[1];
   assign w_mosi      = r_sync2[0];
   assign w_rise      = w_sck & ~r_sck_d;
   assign w_byte_full = {r_shift, w_mosi};

   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync1      <= SYNC_IDLE;
         r_sync2      <= SYNC_IDLE;
         r_sck_d      <= 1'b0;
         r_shift      <= 7'd0;
         r_bitcnt     <= 3'd0;
         r_byte_valid <= 1'b0;
         r_byte       <= 8'd0;
         r_byte_dc    <= 1'b0;
      end else begin
         r_sync1      <= {LCD_reset_n, LCD_clock, LCD_cs_n, LCD_dc, LCD_mosi};
         r_sync2      <= r_sync1;
         r_sck_d      <= w_sck;
         r_byte_valid <= 1'b0;
         if (w_lrst || w_cs_n) begin
            r_bitcnt <= 3'd0;
         end else if (w_rise) begin
            r_shift  <= w_byte_full[6:0];
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
               r_byte_valid <= 1'b1;
               r_byte       <= w_byte_full;
               r_byte_dc    <= w_dc;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_st      <= REGS_RST;
         r_timer   <= '0;
         r_px_put  <= 1'b0;
         r_px_x    <= '0;
         r_px_y    <= '0;
         r_px_data <= 16'd0;
         r_error   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_px_put <= 1'b0;
         if (r_timer != '0)
            r_timer <= r_timer - 1'b1;
         // Held panel reset keeps the busy window loaded so it only counts after release
         if (w_lrst) begin
            r_st    <= REGS_RST;
            r_timer <= TW'(TIMEOUT);
         end else if (r_byte_valid) begin
            if (r_timer != '0) begin
               r_error <= 1'b1;
            end else if (!r_byte_dc) begin
               r_st.state    <= IDLE;
               r_st.pidx     <= 3'd0;
               r_st.hi_valid <= 1'b0;
               case (r_byte)
                  8'h01: begin r_st <= REGS_RST; r_timer <= TW'(TIMEOUT); end
                  8'h10: begin r_st.sleep <= 1'b1; r_timer <= TW'(TIMEOUT); end
                  8'h11: begin r_st.sleep <= 1'b0; r_timer <= TW'(TIMEOUT); end
                  8'h28: r_st.disp_on <= 1'b0;
                  8'h29: r_st.disp_on <= 1'b1;
                  8'h2A: r_st.state <= CASET;
                  8'h2B: r_st.state <= RASET;
                  8'h2C: begin r_st.state <= RAMWR; r_st.x <= r_st.xs; r_st.y <= r_st.ys; end
                  default: ;
               endcase
            end else begin
               case (r_st.state)
                  CASET, RASET: begin
                     if (!r_st.pidx[2]) begin
                        r_st.pidx <= r_st.pidx + 3'd1;
                        case ({r_st.state == RASET, r_st.pidx[1:0]})
                           3'b000: r_st.xs[15:8] <= r_byte;
                           3'b001: r_st.xs[7:0]  <= r_byte;
                           3'b010: r_st.xe[15:8] <= r_byte;
                           3'b011: r_st.xe[7:0]  <= r_byte;
                           3'b100: r_st.ys[15:8] <= r_byte;
                           3'b101: r_st.ys[7:0]  <= r_byte;
                           3'b110: r_st.ye[15:8] <= r_byte;
                           default: r_st.ye[7:0] <= r_byte;
                        endcase
                     end
                  end
                  RAMWR: begin
                     if (!r_st.hi_valid) begin
                        r_st.hi       <= r_byte;
                        r_st.hi_valid <= 1'b1;
                     end else begin
                        r_st.hi_valid <= 1'b0;
                        if (r_st.x < 16'(W) && r_st.y < 16'(H)) begin
                           if (px_full) begin
                              r_overrun <= 1'b1;
                           end else begin
                              r_px_put  <= 1'b1;
                              r_px_x    <= r_st.x[XW-1:0];
                              r_px_y    <= r_st.y[YW-1:0];
                              r_px_data <= {r_st.hi, r_byte};
                           end
                        end
                        // Cursor advances even for dropped pixels so the stream stays aligned
                        if (r_st.x == r_st.xe) begin
                           r_st.x <= r_st.xs;
                           r_st.y <= (r_st.y == r_st.ye) ? r_st.ys : r_st.y + 16'd1;
                        end else begin
                           r_st.x <= r_st.x + 16'd1;
                        end
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

`ifdef SPI_LCD_TARGET_READ_EN
   logic        w_fall;
   logic        r_rd_active, r_miso;
   logic [31:0] r_rd_shift;

   assign w_fall = ~w_sck & r_sck_d;

   // Armed on the 8th rise of RDDID so the first falling edge already shifts a dummy bit
   always_ff @(posedge clock) begin
      if (reset) begin
         r_rd_active <= 1'b0;
         r_rd_shift  <= 32'd0;
         r_miso      <= 1'b0;
      end else if (w_lrst || w_cs_n) begin
         r_rd_active <= 1'b0;
         r_miso      <= 1'b0;
      end else if (w_rise && r_bitcnt == 3'd7 && !w_dc && w_byte_full == 8'h04 && r_timer == '0) begin
         r_rd_active <= 1'b1;
         r_rd_shift  <= {8'h00, 24'h858552};
      end else if (w_fall && r_rd_active) begin
         r_miso     <= r_rd_shift[31];
         r_rd_shift <= {r_rd_shift[30:0], 1'b0};
      end
   end

   assign LCD_miso = r_miso;
`else
   assign LCD_miso = 1'b0;
`endif

   assign px_put  = r_px_put;
   assign px_x    = r_px_x;
   assign px_y    = r_px_y;
   assign px_data = r_px_data;
   assign sleep   = r_st.sleep;
   assign disp_on = r_st.disp_on;
   assign busy    = (r_timer != '0);
   assign error   = r_error;
   assign overrun = r_overrun;
endmodule

// File: tb/tb_spi_lcd_target.sv
// Self-checking bench for spi_lcd_target: directed sequences, a command table and randomized pixel streams.
module tb_spi_lcd_target;
   localparam int W = 240;
   localparam int H = 240;

   logic       clock = 1'b0, reset = 1'b1, LCD_reset_n = 1'b1;
   logic       LCD_clock = 1'b0, LCD_cs_n = 1'b1, LCD_dc = 1'b0, LCD_mosi = 1'b0, px_full = 1'b0;
   logic       LCD_miso, px_put, sleep, disp_on, busy, error, overrun;
   logic [7:0] px_x, px_y;
   logic [15:0] px_data;

   spi_lcd_target #(.W(W), .H(H), .FREQ(1_000_000), .DELAY(1)) dut (
      .reset(reset), .clock(clock), .LCD_reset_n(LCD_reset_n), .LCD_clock(LCD_clock),
      .LCD_cs_n(LCD_cs_n), .LCD_dc(LCD_dc), .LCD_mosi(LCD_mosi), .LCD_miso(LCD_miso),
      .px_x(px_x), .px_y(px_y), .px_data(px_data), .px_put(px_put), .px_full(px_full),
      .sleep(sleep), .disp_on(disp_on), .busy(busy), .error(error), .overrun(overrun)
   );

   always #5 clock = ~clock;

   int errors = 0, checks = 0;
   int busy_cnt = 0;
   int got_rd = 0;
   logic [31:0] got_q[$];
   logic [31:0] exp_q[$];

   always @(negedge clock) begin
      if (px_put) got_q.push_back({px_x, px_y, px_data});
      if (busy) busy_cnt++;
   end

   typedef struct {
      logic [7:0] cmd;
      logic       power;
      logic       exp_sleep;
      logic       exp_disp;
   } vec_t;
   vec_t tbl[6];

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic spi_byte(input logic dcv, input logic [7:0] b);
      LCD_cs_n = 1'b0;
      LCD_dc   = dcv;
      for (int i = 7; i >= 0; i--) begin
         LCD_mosi = b[i];
         tick(3);
         LCD_clock = 1'b1;
         tick(3);
         LCD_clock = 1'b0;
      end
      tick(6);
   endtask

   task automatic end_tx();
      LCD_cs_n = 1'b1;
      tick(3);
   endtask

   task automatic window(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e);
      spi_byte(1'b0, c);
      spi_byte(1'b1, s[15:8]);
      spi_byte(1'b1, s[7:0]);
      spi_byte(1'b1, e[15:8]);
      spi_byte(1'b1, e[7:0]);
   endtask

   task automatic pixel(input logic [15:0] d);
      spi_byte(1'b1, d[15:8]);
      spi_byte(1'b1, d[7:0]);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy === 1'b1 && n < 3000) begin
         tick(1);
         n++;
      end
      chk("busy_timeout", {31'd0, busy}, 32'd0);
   endtask

   function automatic logic [31:0] pk(input int x, input int y, input logic [15:0] d);
      logic [7:0] xb, yb;
      xb = 8'(x);
      yb = 8'(y);
      return {xb, yb, d};
   endfunction

   // Expected writes for a RAMWR stream: walk the window, keep only on-panel pixels
   task automatic model_ramwr(input int xs, input int xe, input int ys, input int ye,
                              input logic [15:0] d[$]);
      int x, y;
      x = xs;
      y = ys;
      foreach (d[i]) begin
         if (x < W && y < H) exp_q.push_back(pk(x, y, d[i]));
         if (x == xe) begin
            x = xs;
            y = (y == ye) ? ys : (y + 1) % 65536;
         end else begin
            x = (x + 1) % 65536;
         end
      end
   endtask

   task automatic compare_writes(input string name);
      tick(4);
      chk({name, "_count"}, got_q.size() - got_rd, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (got_rd + i < got_q.size()) chk(name, got_q[got_rd + i], exp_q[i]);
      got_rd = got_q.size();
      exp_q.delete();
   endtask

   initial begin
      int base;
      logic [15:0] pq[$];
      logic [31:0] rd;

      tbl[0] = '{8'h11, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{8'h29, 1'b0, 1'b0, 1'b1};
      tbl[2] = '{8'h28, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{8'h29, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{8'h10, 1'b1, 1'b1, 1'b1};
      tbl[5] = '{8'h11, 1'b1, 1'b0, 1'b1};

      tick(5);
      reset = 1'b0;
      tick(2);
      chk("rst_px_put", {31'd0, px_put}, 32'd0);
      chk("rst_px_x", {24'd0, px_x}, 32'd0);
      chk("rst_px_y", {24'd0, px_y}, 32'd0);
      chk("rst_px_data", {16'd0, px_data}, 32'd0);
      chk("rst_sleep", {31'd0, sleep}, 32'd1);
      chk("rst_disp_on", {31'd0, disp_on}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_error", {31'd0, error}, 32'd0);
      chk("rst_overrun", {31'd0, overrun}, 32'd0);
      chk("rst_miso", {31'd0, LCD_miso}, 32'd0);

      // SWRESET busy window and bytes dropped while busy
      base = busy_cnt;
      spi_byte(1'b0, 8'h01);
      chk("swreset_busy", {31'd0, busy}, 32'd1);
      tick(400);
      spi_byte(1'b0, 8'h00);
      chk("nop_error", {31'd0, error}, 32'd1);
      spi_byte(1'b0, 8'h29);
      chk("busy_drop_disp", {31'd0, disp_on}, 32'd0);
      end_tx();
      wait_idle();
      chk("busy_len", busy_cnt - base, 32'd1000);

      // Command table
      foreach (tbl[i]) begin
         spi_byte(1'b0, tbl[i].cmd);
         end_tx();
         if (tbl[i].power) begin
            chk("power_busy", {31'd0, busy}, 32'd1);
            wait_idle();
         end
         chk("tbl_sleep", {31'd0, sleep}, {31'd0, tbl[i].exp_sleep});
         chk("tbl_disp", {31'd0, disp_on}, {31'd0, tbl[i].exp_disp});
      end

      // Window and cursor wrap
      window(8'h2A, 16'd10, 16'd11);
      window(8'h2B, 16'd5, 16'd6);
      spi_byte(1'b0, 8'h2C);
      pixel(16'hF800); pixel(16'h07E0); pixel(16'h001F); pixel(16'hFFFF); pixel(16'h1234);
      end_tx();
      exp_q.push_back(pk(10, 5, 16'hF800));
      exp_q.push_back(pk(11, 5, 16'h07E0));
      exp_q.push_back(pk(10, 6, 16'h001F));
      exp_q.push_back(pk(11, 6, 16'hFFFF));
      exp_q.push_back(pk(10, 5, 16'h1234));
      compare_writes("ramwr");

      // Off-panel columns are dropped silently
      window(8'h2A, 16'd238, 16'd241);
      spi_byte(1'b0, 8'h2C);
      pixel(16'hA001); pixel(16'hA002); pixel(16'hA003); pixel(16'hA004);
      end_tx();
      exp_q.push_back(pk(238, 5, 16'hA001));
      exp_q.push_back(pk(239, 5, 16'hA002));
      compare_writes("edge");
      chk("edge_overrun", {31'd0, overrun}, 32'd0);

      // Framebuffer full drops one pixel but the cursor still advances
      window(8'h2A, 16'd0, 16'd3);
      window(8'h2B, 16'd5, 16'd5);
      spi_byte(1'b0, 8'h2C);
      pixel(16'h1111);
      px_full = 1'b1;
      pixel(16'hAAAA);
      px_full = 1'b0;
      pixel(16'hBBBB);
      end_tx();
      exp_q.push_back(pk(0, 5, 16'h1111));
      exp_q.push_back(pk(2, 5, 16'hBBBB));
      compare_writes("full");
      chk("full_overrun", {31'd0, overrun}, 32'd1);

      // Partial byte discarded by cs_n high
      spi_byte(1'b0, 8'h28);
      end_tx();
      chk("pre_partial_disp", {31'd0, disp_on}, 32'd0);
      LCD_cs_n = 1'b0;
      LCD_dc   = 1'b0;
      for (int i = 0; i < 5; i++) begin
         LCD_mosi = 1'b1;
         tick(3);
         LCD_clock = 1'b1;
         tick(3);
         LCD_clock = 1'b0;
      end
      end_tx();
      spi_byte(1'b0, 8'h29);
      end_tx();
      chk("partial_disp", {31'd0, disp_on}, 32'd1);

      // Randomized windows and pixel streams
      for (int t = 0; t < 15; t++) begin
         int xs, xe, ys, ye, n;
         xs = $urandom_range(0, 245);
         xe = xs + $urandom_range(0, 4);
         ys = $urandom_range(0, 242);
         ye = ys + $urandom_range(0, 2);
         n  = $urandom_range(1, 10);
         pq.delete();
         for (int i = 0; i < n; i++) pq.push_back(16'($urandom));
         window(8'h2A, 16'(xs), 16'(xe));
         if ($urandom_range(0, 1) == 1) end_tx();
         window(8'h2B, 16'(ys), 16'(ye));
         spi_byte(1'b0, 8'h2C);
         foreach (pq[i]) pixel(pq[i]);
         if ($urandom_range(0, 1) == 1) spi_byte(1'b1, 8'($urandom));
         end_tx();
         model_ramwr(xs, xe, ys, ye, pq);
         compare_writes("rand");
      end

      // Panel hard reset acts like SWRESET and restores the full window
      LCD_reset_n = 1'b0;
      tick(20);
      chk("lrst_busy", {31'd0, busy}, 32'd1);
      chk("lrst_sleep", {31'd0, sleep}, 32'd1);
      chk("lrst_disp", {31'd0, disp_on}, 32'd0);
      LCD_reset_n = 1'b1;
      tick(3);
      wait_idle();
      spi_byte(1'b0, 8'h2C);
      pixel(16'h5A5A); pixel(16'hC3C3);
      end_tx();
      exp_q.push_back(pk(0, 0, 16'h5A5A));
      exp_q.push_back(pk(1, 0, 16'hC3C3));
      compare_writes("lrst_ramwr");

      // RDDID readback
      rd = 32'd0;
      spi_byte(1'b0, 8'h04);
      for (int i = 0; i < 32; i++) begin
         tick(4);
         rd = {rd[30:0], LCD_miso};
         LCD_clock = 1'b1;
         tick(4);
         LCD_clock = 1'b0;
      end
`ifdef SPI_LCD_TARGET_READ_EN
      chk("rddid", {8'd0, rd[23:0]}, 32'h00858552);
`else
      chk("miso_idle", rd, 32'd0);
`endif
      end_tx();
      chk("miso_after_cs", {31'd0, LCD_miso}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
